// File: rtl/sn76489_bus_writer.sv
// sn76489_bus_writer
//   Host-side write master for sn76489_top. It accepts one register-write
//   request per valid/ready handshake. Each request is encoded as a latch
//   byte, or as a latch byte followed by a data byte. Each byte is driven
//   onto the chip's CE/WE/READY bus with a full ready-stall handshake.
//
// Parameters
//   SETUP_CYCLES   : cycles d_o is stable with strobes high before CE/WE (>= 1)
//   RECOVER_CYCLES : strobe-high cycles after each byte (>= 1)
//   TIMEOUT_CYCLES : maximum cycles allowed in each wait state before abort
//
// Ports
//   clock_i      system clock, shared with sn76489_top
//   res_n_i      asynchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  request accepted on a clock edge when valid and ready are both high
//   req_reg_i    register index: [2:1] channel (3 = noise), [0] 1 = attenuation
//   req_data_i   register value (only the low bits relevant to the register are used)
//   ce_n_o       chip enable, active low
//   we_n_o       write enable, active low
//   d_o          bus byte; bit 7 is the latch flag
//   ready_i      chip ready; low while the chip absorbs a byte
//   busy_o       high whenever the writer is not idle
//   done_o       one-cycle pulse when a request completes
//   err_o        one-cycle pulse on a handshake timeout
//
// Every output is a register. No combinational path exists from ready_i or
// req_* to any output.

module sn76489_bus_writer #(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic       clock_i,
    input  logic       res_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [2:0] req_reg_i,
    input  logic [9:0] req_data_i,
    output logic       ce_n_o,
    output logic       we_n_o,
    output logic [7:0] d_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    // One counter serves every timed state. It is cleared on each state
    // entry, so it only needs to hold the largest terminal count.
    localparam int unsigned MAX_A = (SETUP_CYCLES > RECOVER_CYCLES) ? SETUP_CYCLES : RECOVER_CYCLES;
    localparam int unsigned MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CW    = (MAX_C > 2) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] RECOVER_LAST = CW'(RECOVER_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_b_q, byte_b_d;
    logic          b_pend_q, b_pend_d;
    logic          aborted_q, aborted_d;
    logic [7:0]    d_d;
    logic          strobe_n_d;
    logic          req_ready_d;
    logic          busy_d;
    logic          done_d;
    logic          err_d;

    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            byte_b_q    <= '0;
            b_pend_q    <= 1'b0;
            aborted_q   <= 1'b0;
            d_o         <= '0;
            ce_n_o      <= 1'b1;
            we_n_o      <= 1'b1;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_b_q    <= byte_b_d;
            b_pend_q    <= b_pend_d;
            aborted_q   <= aborted_d;
            d_o         <= d_d;
            ce_n_o      <= strobe_n_d;
            we_n_o      <= strobe_n_d;
            req_ready_o <= req_ready_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            err_o       <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        byte_b_d   = byte_b_q;
        b_pend_d   = b_pend_q;
        aborted_d  = aborted_q;
        d_d        = d_o;
        strobe_n_d = ce_n_o;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid_i && req_ready_o) begin
                    d_d       = {1'b1, req_reg_i, req_data_i[3:0]};
                    byte_b_d  = {2'b00, req_data_i[9:4]};
                    // Only the tone frequency registers 0, 2 and 4 carry a data byte.
                    b_pend_d  = !req_reg_i[0] && (req_reg_i != 3'd6);
                    aborted_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end

            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d      = '0;
                    strobe_n_d = 1'b0;
                    state_d    = S_STROBE;
                end
            end

            S_STROBE: begin
                cnt_d   = '0;
                state_d = S_WAIT_LOW;
            end

            S_WAIT_LOW: begin
                if (!ready_i) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_HIGH;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d      = '0;
                    strobe_n_d = 1'b1;
                    err_d      = 1'b1;
                    b_pend_d   = 1'b0;
                    aborted_d  = 1'b1;
                    state_d    = S_RECOVER;
                end
            end

            S_WAIT_HIGH: begin
                if (ready_i) begin
                    cnt_d      = '0;
                    strobe_n_d = 1'b1;
                    state_d    = S_RECOVER;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d      = '0;
                    strobe_n_d = 1'b1;
                    err_d      = 1'b1;
                    b_pend_d   = 1'b0;
                    aborted_d  = 1'b1;
                    state_d    = S_RECOVER;
                end
            end

            S_RECOVER: begin
                if (cnt_q == RECOVER_LAST) begin
                    cnt_d = '0;
                    if (b_pend_q) begin
                        d_d      = byte_b_q;
                        b_pend_d = 1'b0;
                        state_d  = S_SETUP;
                    end else begin
                        done_d  = !aborted_q;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                cnt_d      = '0;
                strobe_n_d = 1'b1;
                state_d    = S_IDLE;
            end
        endcase

        // Ready is raised only after a full cycle in IDLE. As a result it
        // rises in the cycle after the done/err completion cycle.
        req_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_sn76489_bus_writer.sv
module tb_sn76489_bus_writer;

    localparam int unsigned S = 1;
    localparam int unsigned R = 2;
    localparam int unsigned T = 1023;

    logic       clock_i;
    logic       res_n_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [2:0] req_reg_i;
    logic [9:0] req_data_i;
    logic       ce_n_o;
    logic       we_n_o;
    logic [7:0] d_o;
    logic       ready_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    sn76489_bus_writer #(
        .SETUP_CYCLES   (S),
        .RECOVER_CYCLES (R),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock_i     (clock_i),
        .res_n_i     (res_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_reg_i   (req_reg_i),
        .req_data_i  (req_data_i),
        .ce_n_o      (ce_n_o),
        .we_n_o      (we_n_o),
        .d_o         (d_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Responder behaviour for the chip model
    int unsigned resp_delay = 1;
    int unsigned resp_low   = 32;
    logic        resp_stuck = 1'b0;
    logic        resp_idle  = 1'b1;

    // Bus monitor log
    logic [7:0]  bytes [16];
    int unsigned nbytes    = 0;
    int unsigned gaps [16];
    int unsigned ngaps     = 0;
    int unsigned nstrobe   = 0;
    int unsigned gap_run   = 0;
    int unsigned low_run   = 0;
    int unsigned last_low  = 0;
    int unsigned ndone     = 0;
    int unsigned nerr      = 0;
    int unsigned d_glitch  = 0;
    int unsigned both_high = 0;
    int unsigned split     = 0;
    logic        prev_ce   = 1'b1;
    logic [7:0]  cur_d     = 8'h00;

    initial begin : monitor
        forever begin
            @(negedge clock_i);
            if (ce_n_o === 1'b0 && prev_ce === 1'b1) begin
                if (nbytes < 16) bytes[nbytes] = d_o;
                nbytes++;
                if (nstrobe > 0 && ngaps < 16) begin
                    gaps[ngaps] = gap_run;
                    ngaps++;
                end
                nstrobe++;
                cur_d   = d_o;
                low_run = 0;
            end
            if (ce_n_o === 1'b1 && prev_ce === 1'b0) last_low = low_run;
            if (ce_n_o === 1'b0 && d_o !== cur_d) d_glitch++;
            if (ce_n_o === 1'b1) gap_run++;
            else begin
                gap_run = 0;
                low_run++;
            end
            if (done_o === 1'b1) ndone++;
            if (err_o === 1'b1) nerr++;
            if (done_o === 1'b1 && err_o === 1'b1) both_high++;
            if (res_n_i === 1'b1 && we_n_o !== ce_n_o) split++;
            prev_ce = ce_n_o;
        end
    end

    initial begin : responder
        ready_i = 1'b1;
        forever begin
            @(posedge clock_i);
            #1;
            if (res_n_i === 1'b1 && ce_n_o === 1'b0) begin
                resp_idle = 1'b0;
                if (!resp_stuck) begin
                    repeat (resp_delay) @(posedge clock_i);
                    #1 ready_i = 1'b0;
                    repeat (resp_low) @(posedge clock_i);
                    #1 ready_i = 1'b1;
                end
                for (int k = 0; k < 4000 && ce_n_o !== 1'b1; k++) begin
                    @(posedge clock_i);
                    #1;
                end
                resp_idle = 1'b1;
            end
        end
    end

    task automatic clear_log();
        nbytes  = 0;
        ngaps   = 0;
        nstrobe = 0;
        gap_run = 0;
        ndone   = 0;
        nerr    = 0;
    endtask

    task automatic do_req(input logic [2:0] r, input logic [9:0] v);
        int unsigned k;
        k = 0;
        @(negedge clock_i);
        while (req_ready_o !== 1'b1 && k < 3000) begin
            @(negedge clock_i);
            k++;
        end
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL req_accept: req_ready_o=%b required 1", req_ready_o);
        end
        req_valid_i = 1'b1;
        req_reg_i   = r;
        req_data_i  = v;
        @(posedge clock_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        @(negedge clock_i);
        while (!(busy_o === 1'b0 && req_ready_o === 1'b1) && k < 5000) begin
            @(negedge clock_i);
            k++;
        end
        n_cmp++;
        if (!(busy_o === 1'b0 && req_ready_o === 1'b1)) begin
            n_fail++;
            $display("FAIL idle_wait: busy_o=%b req_ready_o=%b required 0/1", busy_o, req_ready_o);
        end
        repeat (2) @(negedge clock_i);
    endtask

    task automatic wait_resp_idle();
        for (int k = 0; k < 200 && resp_idle !== 1'b1; k++) @(negedge clock_i);
        n_cmp++;
        if (resp_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_idle: responder still busy, required idle");
        end
    endtask

    task automatic test_reset();
        res_n_i     = 1'b1;
        req_valid_i = 1'b0;
        req_reg_i   = '0;
        req_data_i  = '0;
        #2 res_n_i  = 1'b0;
        #1;
        n_cmp++;
        if ({ce_n_o, we_n_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_strobes: ce_n/we_n=%b required 11", {ce_n_o, we_n_o});
        end
        n_cmp++;
        if (d_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_d: d_o=%h required 00", d_o);
        end
        n_cmp++;
        if ({req_ready_o, busy_o, done_o, err_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: ready/busy/done/err=%b required 1000",
                     {req_ready_o, busy_o, done_o, err_o});
        end
        repeat (3) @(negedge clock_i);
        res_n_i = 1'b1;
        repeat (2) @(negedge clock_i);
    endtask

    task automatic test_two_byte_reg0();
        resp_delay = 1;
        resp_low   = 32;
        clear_log();
        do_req(3'd0, 10'h3FF);
        wait_idle();
        wait_resp_idle();
        n_cmp++;
        if (nbytes != 2) begin
            n_fail++;
            $display("FAIL reg0_nbytes: got %0d required 2", nbytes);
        end
        n_cmp++;
        if (bytes[0] !== 8'h8F || bytes[1] !== 8'h3F) begin
            n_fail++;
            $display("FAIL reg0_bytes: got %h %h required 8f 3f", bytes[0], bytes[1]);
        end
        n_cmp++;
        if (ndone != 1 || nerr != 0) begin
            n_fail++;
            $display("FAIL reg0_done: done=%0d err=%0d required 1/0", ndone, nerr);
        end
        n_cmp++;
        if (gaps[0] != R + S) begin
            n_fail++;
            $display("FAIL reg0_inner_gap: got %0d required %0d", gaps[0], R + S);
        end
        n_cmp++;
        if (d_glitch != 0) begin
            n_fail++;
            $display("FAIL reg0_d_stable: %0d changes while strobed, required 0", d_glitch);
        end
    endtask

    task automatic test_single_reg3();
        int unsigned lat;
        clear_log();
        do_req(3'd3, 10'h3F5);
        lat = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clock_i);
            #1;
            lat++;
            if (done_o === 1'b1) break;
        end
        n_cmp++;
        // setup + strobe + one WAIT_LOW cycle + 32 WAIT_HIGH cycles + recover
        if (lat != S + 1 + 1 + 32 + R) begin
            n_fail++;
            $display("FAIL reg3_latency: got %0d required %0d", lat, S + 1 + 1 + 32 + R);
        end
        wait_idle();
        wait_resp_idle();
        n_cmp++;
        if (nbytes != 1 || bytes[0] !== 8'hB5) begin
            n_fail++;
            $display("FAIL reg3_byte: n=%0d byte=%h required 1 b5", nbytes, bytes[0]);
        end
        n_cmp++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL reg3_done: got %0d required 1", ndone);
        end
    endtask

    task automatic test_noise_reg6();
        clear_log();
        do_req(3'd6, 10'h004);
        wait_idle();
        wait_resp_idle();
        n_cmp++;
        if (nbytes != 1 || bytes[0] !== 8'hE4) begin
            n_fail++;
            $display("FAIL reg6_byte: n=%0d byte=%h required 1 e4", nbytes, bytes[0]);
        end
        n_cmp++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL reg6_done: got %0d required 1", ndone);
        end
    endtask

    task automatic test_timeout();
        int unsigned k;
        resp_stuck = 1'b1;
        clear_log();
        do_req(3'd0, 10'h123);
        k = 0;
        @(negedge clock_i);
        while (err_o !== 1'b1 && k < T + 200) begin
            @(negedge clock_i);
            k++;
        end
        n_cmp++;
        if (err_o !== 1'b1 || ce_n_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err: err_o=%b ce_n_o=%b required 1/1", err_o, ce_n_o);
        end
        k = 0;
        while (req_ready_o !== 1'b1 && k < 20) begin
            @(negedge clock_i);
            k++;
        end
        n_cmp++;
        if (k < R || k > R + 1) begin
            n_fail++;
            $display("FAIL timeout_ready: ready after %0d cycles required %0d..%0d", k, R, R + 1);
        end
        wait_idle();
        wait_resp_idle();
        n_cmp++;
        if (last_low != T + 1) begin
            n_fail++;
            $display("FAIL timeout_len: strobe low %0d cycles required %0d", last_low, T + 1);
        end
        n_cmp++;
        if (nerr != 1 || ndone != 0) begin
            n_fail++;
            $display("FAIL timeout_pulses: err=%0d done=%0d required 1/0", nerr, ndone);
        end
        n_cmp++;
        if (nbytes != 1 || bytes[0] !== 8'h83) begin
            n_fail++;
            $display("FAIL timeout_bytes: n=%0d byte=%h required 1 83", nbytes, bytes[0]);
        end
        resp_stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        int unsigned k;
        clear_log();
        do_req(3'd2, 10'h2A5);
        k = 0;
        while (nbytes < 2 && k < 200) begin
            @(negedge clock_i);
            k++;
        end
        repeat (5) @(negedge clock_i);
        #2 res_n_i = 1'b0;
        #1;
        n_cmp++;
        if ({ce_n_o, we_n_o} !== 2'b11 || d_o !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_bus: ce_n/we_n=%b d_o=%h required 11 00", {ce_n_o, we_n_o}, d_o);
        end
        n_cmp++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_flags: ready=%b busy=%b required 1/0", req_ready_o, busy_o);
        end
        @(negedge clock_i);
        res_n_i = 1'b1;
        wait_resp_idle();
        repeat (10) @(negedge clock_i);
        n_cmp++;
        if (ndone != 0 || nerr != 0) begin
            n_fail++;
            $display("FAIL midreset_pulses: done=%0d err=%0d required 0/0", ndone, nerr);
        end
        n_cmp++;
        if (bytes[0] !== 8'hA5 || bytes[1] !== 8'h2A) begin
            n_fail++;
            $display("FAIL midreset_bytes: got %h %h required a5 2a", bytes[0], bytes[1]);
        end
        clear_log();
        do_req(3'd1, 10'h00A);
        wait_idle();
        wait_resp_idle();
        n_cmp++;
        if (ndone != 1 || nbytes != 1 || bytes[0] !== 8'h9A) begin
            n_fail++;
            $display("FAIL after_reset_req: done=%0d n=%0d byte=%h required 1 1 9a",
                     ndone, nbytes, bytes[0]);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned k;
        clear_log();
        @(negedge clock_i);
        req_valid_i = 1'b1;
        req_reg_i   = 3'd4;
        req_data_i  = 10'h001;
        k = 0;
        while (req_ready_o !== 1'b1 && k < 200) begin
            @(negedge clock_i);
            k++;
        end
        @(posedge clock_i);
        #1;
        req_reg_i  = 3'd5;
        req_data_i = 10'h00F;
        @(negedge clock_i);
        k = 0;
        while (req_ready_o !== 1'b1 && k < 400) begin
            @(negedge clock_i);
            k++;
        end
        @(posedge clock_i);
        #1;
        req_valid_i = 1'b0;
        wait_idle();
        wait_resp_idle();
        n_cmp++;
        if (nbytes != 3) begin
            n_fail++;
            $display("FAIL b2b_nbytes: got %0d required 3", nbytes);
        end
        n_cmp++;
        if (bytes[0] !== 8'hC1 || bytes[1] !== 8'h00 || bytes[2] !== 8'hDF) begin
            n_fail++;
            $display("FAIL b2b_bytes: got %h %h %h required c1 00 df", bytes[0], bytes[1], bytes[2]);
        end
        n_cmp++;
        if (ndone != 2) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d required 2", ndone);
        end
        n_cmp++;
        if (gaps[0] != R + S || gaps[1] < R + S) begin
            n_fail++;
            $display("FAIL b2b_gaps: got %0d %0d required %0d and >=%0d", gaps[0], gaps[1], R + S, R + S);
        end
        n_cmp++;
        if (both_high != 0 || split != 0) begin
            n_fail++;
            $display("FAIL pulse_exclusive: done&err=%0d ce/we split=%0d required 0/0", both_high, split);
        end
    endtask

    initial begin
        test_reset();
        test_two_byte_reg0();
        test_single_reg3();
        test_noise_reg6();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
